// File: rtl/mem_responder.sv
// Memory-side responder that arbitrates instruction and data requests onto a single-ported RAM.
// Optional RAM watchdog is enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_responder #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_lastData;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic [31:0] r_iload;
    logic [31:0] r_dload;
    logic        r_err;

    logic        w_dReq;
    logic        w_iReq;
    logic        w_grant;
    logic        w_grantData;
    logic        w_busy;
    logic        w_timeout;
    logic        w_fail;
    logic        w_finish;
    logic [31:0] w_resp;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] r_count;

    // Watchdog counts cycles spent waiting on the RAM since the grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_grant) begin
            r_count <= '0;
        end else if (w_busy) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Round-robin only matters on contention: the side not served last wins.
    always_comb begin
        w_dReq      = dREN | dWEN;
        w_iReq      = iREN & ~halt;
        w_grantData = w_dReq & (~w_iReq | ~r_lastData);
        w_grant     = (r_state == IDLE) & (w_dReq | w_iReq);
        w_busy      = (r_state == INSTR) | (r_state == DATA);
        w_fail      = w_busy & ((ramstate == RAM_ERROR) | ((ramstate != RAM_ACCESS) & w_timeout));
        w_finish    = w_busy & ((ramstate == RAM_ACCESS) | w_fail);
        w_resp      = (w_fail | r_write) ? 32'd0 : ramload;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_nextState = w_grantData ? DATA : INSTR;
                end
            end
            INSTR, DATA: begin
                if (w_finish) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request fields are frozen at grant so the RAM sees a stable transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lastData <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_store    <= '0;
            r_iload    <= '0;
            r_dload    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_lastData <= w_grantData;
                r_write    <= w_grantData & dWEN;
                r_addr     <= w_grantData ? daddr : iaddr;
                r_store    <= w_grantData ? dstore : 32'd0;
            end
            if (w_finish) begin
                if (r_lastData) begin
                    r_dload <= w_resp;
                end else begin
                    r_iload <= w_resp;
                end
            end
            if (w_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ramREN   = w_busy & ~r_write;
    assign ramWEN   = w_busy & r_write;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iwait    = ~((r_state == DONE) & ~r_lastData);
    assign dwait    = ~((r_state == DONE) & r_lastData);
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign err      = r_err;

endmodule
